datagram_frame_scheduler: RTL and testbench

DATAGRAM_FRAME_SCHEDULER -- requirements
Module: datagram_frame_scheduler

---
 rtl/datagram_frame_scheduler.sv | 140 ++++++++++++++
 tb/tb_datagram_frame_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datagram_frame_scheduler.sv
// datagram_frame_scheduler
//   Latches datagrams from the game core into a shadow register and commits
//   them to the output only on the rising edge of vblank, so that every
//   frame sees one coherent datagram. When the scene-state field changes,
//   the commit is wrapped in a fade-out / fade-in sequence on fade_level.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   dg_in        datagram from the game core
//   dg_valid     dg_in holds a new datagram
//   dg_ready     shadow register can accept (combinational !pending)
//   vblank       level, high during vertical blanking
//   dg_out       frame-coherent datagram
//   frame_tick   one-cycle pulse in the cycle after each commit edge
//   fade_active  FSM is fading (not IDLE)
//   fade_level   brightness scale 0..15
module datagram_frame_scheduler #(
  parameter int MESSAGE_SIZE = 512,
  parameter int STATE_SIZE   = 3,
  parameter int FADE_STEP    = 5,
  parameter int FADE_EN      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MESSAGE_SIZE-1:0] dg_in,
  input  logic                    dg_valid,
  output logic                    dg_ready,
  input  logic                    vblank,
  output logic [MESSAGE_SIZE-1:0] dg_out,
  output logic                    frame_tick,
  output logic                    fade_active,
  output logic [3:0]              fade_level
);

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } state_e;

  localparam logic [4:0] STEP      = 5'(FADE_STEP);
  localparam logic [4:0] LEVEL_MAX = 5'd15;

  state_e                  state_q, state_d;
  logic [4:0]              level_q, level_d;
  logic [MESSAGE_SIZE-1:0] shadow_q, shadow_d;
  logic [MESSAGE_SIZE-1:0] dg_out_q, dg_out_d;
  logic                    pending_q, pending_d;
  logic                    vblank_q;
  logic                    tick_q, tick_d;

  logic       vb_edge;
  logic       scene_chg;
  logic       accept;
  logic       commit;
  logic [4:0] level_up;

  always_comb begin
    vb_edge   = vblank && !vblank_q;
    scene_chg = (FADE_EN != 0) && pending_q &&
                (shadow_q[STATE_SIZE-1:0] != dg_out_q[STATE_SIZE-1:0]);
    accept    = dg_valid && !pending_q;
    // Compare before adding so the 5-bit sum can never wrap.
    level_up  = (level_q > (LEVEL_MAX - STEP)) ? LEVEL_MAX : (level_q + STEP);

    state_d   = state_q;
    level_d   = level_q;
    shadow_d  = shadow_q;
    dg_out_d  = dg_out_q;
    pending_d = pending_q;
    commit    = 1'b0;

    if (vb_edge) begin
      unique case (state_q)
        IDLE: begin
          if (scene_chg)      state_d = FADE_OUT;
          else if (pending_q) commit  = 1'b1;
        end
        FADE_OUT: begin
          if (level_q > STEP) begin
            level_d = level_q - STEP;
          end else begin
            level_d = '0;
            commit  = 1'b1;
            state_d = FADE_IN;
          end
        end
        FADE_IN: begin
          level_d = level_up;
          // A further scene change waits in the shadow until IDLE.
          if (pending_q && !scene_chg) commit = 1'b1;
          if (level_up == LEVEL_MAX)   state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          level_d = LEVEL_MAX;
        end
      endcase
    end

    // commit needs pending_q=1 and accept needs pending_q=0, so they never collide.
    if (commit) begin
      dg_out_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = dg_in;
      pending_d = 1'b1;
    end
    tick_d = commit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      level_q   <= LEVEL_MAX;
      shadow_q  <= '0;
      dg_out_q  <= '0;
      pending_q <= 1'b0;
      vblank_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      shadow_q  <= shadow_d;
      dg_out_q  <= dg_out_d;
      pending_q <= pending_d;
      vblank_q  <= vblank;
      tick_q    <= tick_d;
    end
  end

  assign dg_ready    = !pending_q;
  assign dg_out      = dg_out_q;
  assign frame_tick  = tick_q;
  assign fade_active = (state_q != IDLE);
  assign fade_level  = level_q[4] ? 4'hF : level_q[3:0];

endmodule

// File: tb/tb_datagram_frame_scheduler.sv
module tb_datagram_frame_scheduler;

  localparam int MS   = 512;
  localparam int SS   = 3;
  localparam int STEP = 5;

  localparam int PH_IDLE = 0;
  localparam int PH_OUT  = 1;
  localparam int PH_IN   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [MS-1:0] dg_in;
  logic          dg_valid;
  logic          vblank;

  logic [MS-1:0] out0, out1;
  logic          tick0, tick1, act0, act1, rdy0, rdy1;
  logic [3:0]    lvl0, lvl1;

  datagram_frame_scheduler #(
    .MESSAGE_SIZE(MS), .STATE_SIZE(SS), .FADE_STEP(STEP), .FADE_EN(1)
  ) dut0 (
    .clk(clk), .rst(rst), .dg_in(dg_in), .dg_valid(dg_valid), .dg_ready(rdy0),
    .vblank(vblank), .dg_out(out0), .frame_tick(tick0), .fade_active(act0),
    .fade_level(lvl0)
  );

  datagram_frame_scheduler #(
    .MESSAGE_SIZE(MS), .STATE_SIZE(SS), .FADE_STEP(STEP), .FADE_EN(0)
  ) dut1 (
    .clk(clk), .rst(rst), .dg_in(dg_in), .dg_valid(dg_valid), .dg_ready(rdy1),
    .vblank(vblank), .dg_out(out1), .frame_tick(tick1), .fade_active(act1),
    .fade_level(lvl1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [MS-1:0] got,
                          input logic [MS-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 has fades enabled, index 1 has them disabled.
  logic [MS-1:0] m_shadow[2];
  logic [MS-1:0] m_out[2];
  bit            m_pend[2];
  bit            m_tick[2];
  int            m_phase[2];
  int            m_level[2];
  bit            m_vb;
  bit            m_acc0;
  bit            m_en[2] = '{1'b1, 1'b0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_shadow[k] = '0;
      m_out[k]    = '0;
      m_pend[k]   = 1'b0;
      m_tick[k]   = 1'b0;
      m_phase[k]  = PH_IDLE;
      m_level[k]  = 15;
    end
    m_vb   = 1'b0;
    m_acc0 = 1'b0;
  endtask

  task automatic model_step();
    bit vb_edge;
    vb_edge = vblank && !m_vb;
    m_vb    = vblank;
    for (int k = 0; k < 2; k++) begin
      bit p_old, commit, scene;
      p_old  = m_pend[k];
      commit = 1'b0;
      scene  = m_en[k] && p_old && (m_shadow[k][SS-1:0] != m_out[k][SS-1:0]);
      if (vb_edge) begin
        case (m_phase[k])
          PH_IDLE: begin
            if (scene)      m_phase[k] = PH_OUT;
            else if (p_old) commit = 1'b1;
          end
          PH_OUT: begin
            if (m_level[k] > STEP) m_level[k] -= STEP;
            else begin
              m_level[k] = 0;
              commit     = 1'b1;
              m_phase[k] = PH_IN;
            end
          end
          default: begin
            m_level[k] = (m_level[k] + STEP > 15) ? 15 : m_level[k] + STEP;
            if (p_old && !scene) commit = 1'b1;
            if (m_level[k] == 15) m_phase[k] = PH_IDLE;
          end
        endcase
      end
      m_tick[k] = commit;
      if (commit) begin
        m_out[k]  = m_shadow[k];
        m_pend[k] = 1'b0;
      end
      if (dg_valid && !p_old) begin
        m_shadow[k] = dg_in;
        m_pend[k]   = 1'b1;
      end
      if (k == 0) m_acc0 = dg_valid && !p_old;
    end
  endtask

  task automatic check_all();
    check_eq("dg_out0",  out0, m_out[0]);
    check_eq("tick0",    MS'(tick0), MS'(m_tick[0]));
    check_eq("level0",   MS'(lvl0), MS'(m_level[0]));
    check_eq("active0",  MS'(act0), MS'(m_phase[0] != PH_IDLE));
    check_eq("ready0",   MS'(rdy0), MS'(!m_pend[0]));
    check_eq("dg_out1",  out1, m_out[1]);
    check_eq("tick1",    MS'(tick1), MS'(m_tick[1]));
    check_eq("level1",   MS'(lvl1), MS'(15));
    check_eq("active1",  MS'(act1), MS'(1'b0));
    check_eq("ready1",   MS'(rdy1), MS'(!m_pend[1]));
  endtask

  // Inputs are driven on the falling edge; the model advances with the
  // rising edge and outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    else     model_reset();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic rand_dg(input logic [SS-1:0] st, output logic [MS-1:0] d);
    for (int i = 0; i < MS / 32; i++) d[i*32 +: 32] = $urandom;
    d[SS-1:0] = st;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    dg_valid = 1'b0;
    vblank   = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  // One frame: two active-video cycles, then the edge cycle, then one more
  // blanking cycle. Level/out are sampled right after the edge cycle.
  task automatic frame(output logic [3:0] lvl_after, output logic [SS-1:0] st_after,
                       output logic tick_after);
    vblank = 1'b0; step(); step();
    vblank = 1'b1; step();
    lvl_after  = lvl0;
    st_after   = out0[SS-1:0];
    tick_after = tick0;
    step();
  endtask

  initial begin
    logic [3:0]    lvl;
    logic [SS-1:0] st;
    logic          tk;
    int            exp_lvl[7] = '{15, 10, 5, 0, 5, 10, 15};
    int            vb_cnt;

    dg_in = '0;
    do_reset();
    check_eq("reset_out",   out0, '0);
    check_eq("reset_level", MS'(lvl0), MS'(15));
    check_eq("reset_ready", MS'(rdy0), MS'(1'b1));

    // Scene change from reset state 0 to state 3: full fade sequence.
    rand_dg(3'd3, dg_in);
    dg_valid = 1'b1;
    step();
    dg_valid = 1'b0;
    for (int e = 0; e < 7; e++) begin
      frame(lvl, st, tk);
      check_eq($sformatf("fade_lvl_e%0d", e + 1), MS'(lvl), MS'(exp_lvl[e]));
      check_eq($sformatf("fade_st_e%0d", e + 1), MS'(st), MS'((e >= 3) ? 3 : 0));
      check_eq($sformatf("fade_tick_e%0d", e + 1), MS'(tk), MS'(e == 3));
      check_eq($sformatf("fade_act_e%0d", e + 1), MS'(act0), MS'(e < 6));
    end

    // Accept landing in the edge cycle itself: no commit until the next edge.
    vblank = 1'b0; step(); step();
    rand_dg(3'd3, dg_in);
    dg_valid = 1'b1;
    vblank   = 1'b1;
    step();
    dg_valid = 1'b0;
    check_eq("edge_accept_nocommit", MS'(rdy0), MS'(1'b0));
    step();
    frame(lvl, st, tk);
    check_eq("edge_accept_commit", MS'(tk), MS'(1'b1));

    // Asynchronous reset while fading out at level 5 with a datagram pending.
    do_reset();
    rand_dg(3'd2, dg_in);
    dg_valid = 1'b1;
    step();
    dg_valid = 1'b0;
    for (int e = 0; e < 3; e++) frame(lvl, st, tk);
    check_eq("pre_rst_level", MS'(lvl0), MS'(5));
    check_eq("pre_rst_pend",  MS'(rdy0), MS'(1'b0));
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_level",  MS'(lvl0), MS'(15));
    check_eq("async_rst_active", MS'(act0), MS'(1'b0));
    check_eq("async_rst_ready",  MS'(rdy0), MS'(1'b1));
    check_eq("async_rst_out",    out0, '0);
    check_all();
    @(negedge clk);
    step();
    rst = 1'b1;

    // Randomized traffic with random frame timing and occasional resets.
    dg_valid = 1'b0;
    vblank   = 1'b0;
    vb_cnt   = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (vb_cnt == 0) begin
        vblank = !vblank;
        vb_cnt = vblank ? $urandom_range(1, 3) : $urandom_range(2, 9);
      end
      vb_cnt--;
      if (!dg_valid || m_acc0) begin
        dg_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 1) == 1) st = m_out[0][SS-1:0];
        else                           st = SS'($urandom_range(0, 3));
        rand_dg(st, dg_in);
      end
      rst = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
